dmem_requester: RTL and testbench
=================================

# dmem_requester

Initiator side of the data-memory interface for the Y86-64 processor. It takes the memory-stage operands (icode, valA, valE, valP), decides whether and how to access memory, and drives a valid/ready request channel to a multi-cycle data-memory responder. It returns valM and dmem_error to write-back, and holds the pipeline with a stall while an access is outstanding.

## Interface
- ADDR_LIMIT, 8192: first illegal word address; any access with address >= ADDR_LIMIT is an error.
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before aborting with an error; counter width is $clog2(TIMEOUT+1).
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  memory-stage operands valid
- in_ready  out  1  block idle, accepts operands (= state IDLE)
- stall  out  1  ~in_ready; freezes upstream stages
- icode  in  4  instruction code
- valA, valE, valP  in  64  each: memory-stage operands
- done  out  1  one-cycle pulse: result valid
- valM  out  64  read data; 0 for non-reads and errors
- dmem_error  out  1  valid with done: address out of range or timeout
- mem_req  out  1  request valid to responder
- mem_ready  in  1  responder accepts request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  64  word address
- mem_wdata  out  64  write data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  64  read data

## Operation
- Decode on acceptance (in_valid & in_ready), latched into registers:
  - Reads: mrmovq 5 (addr valE), ret 9 (addr valA), popq B (addr valA).
  - Writes: rmmovq 4 (addr valE, data valA), call 8 (addr valE, data valP), pushq A (addr valE, data valA).
  - Any other icode: no access.
- States: IDLE, REQ, WAIT, RESP.
- IDLE, on accept:
  - No access -> RESP, error 0, valM 0.
  - Address >= ADDR_LIMIT -> RESP, error 1, valM 0; no mem_req is ever raised.
  - Otherwise -> REQ.
- REQ:
  - mem_req=1; mem_we, mem_addr and mem_wdata are stable from registers.
  - On mem_ready: a write -> RESP; a read -> WAIT.
- WAIT:
  - On mem_rvalid: capture mem_rdata into valM -> RESP.
  - mem_rvalid is ignored in any other state.
- Timeout counter:
  - Cleared on entry to REQ; increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT with no completing event -> RESP with error 1, valM 0, mem_req dropped.
  - A completing event in the same cycle as timeout wins (no error).
- RESP: done=1 for exactly one cycle, then IDLE.
- valM and dmem_error hold their value until the next acceptance.
- Reset (async, any time, including mid-request):
  - state IDLE, counter 0, mem_req 0, done 0, valM 0, dmem_error 0, mem_we 0, mem_addr 0, mem_wdata 0.
  - Therefore in_ready=1 and stall=0.
  - An aborted request is not retried.

## Timing
- Acceptance at edge E0.
- Write with mem_ready high in the first REQ cycle: handshake at E1, done high in the cycle after E1.
- Read with mem_ready at E1 and mem_rvalid in the next cycle: rdata captured at E2, done in the cycle after E2.
- Non-memory icode or out-of-range address: done in the cycle after E0.
- Timeout: done in the cycle after the TIMEOUT-th REQ/WAIT edge.
- in_ready is 0 from the cycle after E0 until the cycle after RESP, so back-to-back operations are spaced by at least 2 cycles.
- Outputs are registered; there is no combinational path from the mem_* inputs to done, valM or dmem_error.

## Structure
- Shared package y86_pkg holds the icode constants (IHALT..IPOPQ), a mem_op_e enum (NONE, READ, WRITE) and the state enum.
- One combinational sub-module, dmem_op_decode: maps icode, valA, valE and valP to op, addr and wdata.
- The FSM and timeout counter live in dmem_requester.

## Test plan
- rmmovq: icode 4, valE 0x10, valA 0xDEAD, mem_ready held 1. Expect one request, mem_we 1, addr 0x10, wdata 0xDEAD; done 2 cycles after accept; error 0.
- mrmovq: icode 5, valE 0x20, ready after 3 cycles, rvalid 2 cycles later with rdata 0xCAFE. Expect valM 0xCAFE, error 0; stall high throughout.
- pushq: icode A, valE 8192. Expect no mem_req, done next cycle, error 1, valM 0.
- popq: icode B, valA 0x8, mem_ready never asserted, TIMEOUT 4. Expect mem_req dropped, done with error 1 after 4 cycles.
- Reset: assert rst_n=0 while in WAIT. Expect immediate mem_req 0 and in_ready 1. A following nop (icode 1) gives done with valM 0 and no request.
- ret: icode 9, valA 0x30, with rvalid pulsed during REQ. Expect that rvalid ignored; the later rvalid in WAIT with 0x1234 gives valM 0x1234.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 definitions for the memory-stage requester.
//   - icode constants IHALT..IPOPQ
//   - mem_op_e: kind of data-memory access an instruction needs
//   - dmem_state_e: requester FSM states
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/dmem_requester_if.sv
// dmem_requester_if: valid/ready request channel between the memory-stage
// requester (master) and the multi-cycle data-memory responder (slave).
//   mem_req    master->slave  request valid
//   mem_ready  slave->master  request accepted
//   mem_we     master->slave  1 = write, 0 = read
//   mem_addr   master->slave  64-bit word address
//   mem_wdata  master->slave  64-bit write data
//   mem_rvalid slave->master  read data valid
//   mem_rdata  slave->master  64-bit read data
interface dmem_requester_if;
  logic        mem_req;
  logic        mem_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dmem_op_decode.sv
// dmem_op_decode: purely combinational map from memory-stage operands to
// the access to perform.
//   i_icode           instruction code
//   i_valA/E/P        memory-stage operands
//   o_op              OP_NONE / OP_READ / OP_WRITE
//   o_addr, o_wdata   access address and write data
module dmem_op_decode
  import y86_pkg::*;
(
  input  logic [3:0]  i_icode,
  input  logic [63:0] i_valA,
  input  logic [63:0] i_valE,
  input  logic [63:0] i_valP,
  output mem_op_e     o_op,
  output logic [63:0] o_addr,
  output logic [63:0] o_wdata
);

  always_comb begin
    o_op    = OP_NONE;
    o_addr  = i_valE;
    o_wdata = i_valA;
    case (i_icode)
      IMRMOVQ: o_op = OP_READ;
      IRET, IPOPQ: begin
        // stack pops read from the old %rsp carried in valA
        o_op   = OP_READ;
        o_addr = i_valA;
      end
      IRMMOVQ, IPUSHQ: o_op = OP_WRITE;
      ICALL: begin
        // call pushes the return address
        o_op    = OP_WRITE;
        o_wdata = i_valP;
      end
      default: o_op = OP_NONE;
    endcase
  end

endmodule

// File: rtl/dmem_requester.sv
// dmem_requester: memory-stage initiator for the Y86-64 data memory.
// Accepts operands when idle, issues at most one request on the mem
// channel, waits for read data, and returns valM / dmem_error with a
// one-cycle done pulse. stall holds upstream stages while busy.
//   clk, rst_n        clock, async active-low reset
//   in_valid/in_ready operand handshake (in_ready = idle)
//   stall             ~in_ready
//   icode, valA/E/P   memory-stage operands
//   done              one-cycle result strobe
//   valM, dmem_error  result, held until the next acceptance
//   mem               master side of the data-memory channel
//
// state | meaning
// IDLE  | waiting for operands
// REQ   | mem_req high, waiting for mem_ready
// WAIT  | read accepted, waiting for mem_rvalid
// RESP  | done high for one cycle
module dmem_requester
  import y86_pkg::*;
#(
  parameter logic [63:0] ADDR_LIMIT = 64'd8192,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              stall,
  input  logic [3:0]        icode,
  input  logic [63:0]       valA,
  input  logic [63:0]       valE,
  input  logic [63:0]       valP,
  output logic              done,
  output logic [63:0]       valM,
  output logic              dmem_error,
  dmem_requester_if.master  mem
);

  localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  mem_op_e     w_op;
  logic [63:0] w_addr;
  logic [63:0] w_wdata;
  logic        w_oob;

  dmem_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic        r_mem_req;
  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_done;
  logic [63:0] r_valm;
  logic        r_err;

  dmem_op_decode u_decode (
    .i_icode (icode),
    .i_valA  (valA),
    .i_valE  (valE),
    .i_valP  (valP),
    .o_op    (w_op),
    .o_addr  (w_addr),
    .o_wdata (w_wdata)
  );

  assign w_oob = (w_addr >= ADDR_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mem_req <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_done    <= 1'b0;
      r_valm    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_we    <= (w_op == OP_WRITE);
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_valm  <= '0;
            r_cnt   <= '0;
            if (w_op == OP_NONE) begin
              r_err   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= RESP;
            end else if (w_oob) begin
              // bad address never reaches the responder
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= RESP;
            end else begin
              r_err     <= 1'b0;
              r_mem_req <= 1'b1;
              r_state   <= REQ;
            end
          end
        end
        REQ: begin
          r_cnt <= r_cnt + CNT_ONE;
          // handshake is checked first so it beats a same-cycle timeout
          if (mem.mem_ready) begin
            r_mem_req <= 1'b0;
            if (r_we) begin
              r_done  <= 1'b1;
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= RESP;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (mem.mem_rvalid) begin
            r_valm  <= mem.mem_rdata;
            r_done  <= 1'b1;
            r_state <= RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == IDLE);
  assign stall         = ~in_ready;
  assign done          = r_done;
  assign valM          = r_valm;
  assign dmem_error    = r_err;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_requester.sv
// Directed bench for dmem_requester. Instance a uses the default TIMEOUT,
// instance b uses TIMEOUT=4 for the timeout scenarios.
module tb_dmem_requester;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_a, in_valid_b;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic        in_ready_a, stall_a, done_a, err_a;
  logic        in_ready_b, stall_b, done_b, err_b;
  logic [63:0] valM_a, valM_b;

  int n_cmp = 0;
  int n_err = 0;
  int req_cyc_a = 0;
  int hs_a = 0;

  dmem_requester_if if_a ();
  dmem_requester_if if_b ();

  dmem_requester dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .stall(stall_a), .icode(icode), .valA(valA), .valE(valE), .valP(valP),
    .done(done_a), .valM(valM_a), .dmem_error(err_a), .mem(if_a.master)
  );

  dmem_requester #(.TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .stall(stall_b), .icode(icode), .valA(valA), .valE(valE), .valP(valP),
    .done(done_b), .valM(valM_b), .dmem_error(err_b), .mem(if_b.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (if_a.mem_req) req_cyc_a <= req_cyc_a + 1;
    if (if_a.mem_req && if_a.mem_ready) hs_a <= hs_a + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0h exp 1", in_ready_a); end
    n_cmp++; if (stall_a !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0h exp 0", stall_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL rst_done: got %0h exp 0", done_a); end
    n_cmp++; if (valM_a !== 64'h0) begin n_err++; $display("FAIL rst_valM: got %0h exp 0", valM_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_err++; $display("FAIL rst_err: got %0h exp 0", err_a); end
    n_cmp++; if ({if_a.mem_req, if_a.mem_we} !== 2'b00) begin n_err++; $display("FAIL rst_req_we: got %0h exp 0", {if_a.mem_req, if_a.mem_we}); end
    n_cmp++; if ({if_a.mem_addr, if_a.mem_wdata} !== 128'h0) begin n_err++; $display("FAIL rst_addr_wdata: got %0h exp 0", {if_a.mem_addr, if_a.mem_wdata}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rmmovq();
    int hs0;
    hs0 = hs_a;
    icode = 4'h4; valE = 64'h10; valA = 64'hDEAD; valP = 64'h99;
    if_a.mem_ready = 1'b1; in_valid_a = 1'b1;
    tick(); in_valid_a = 1'b0;
    n_cmp++; if (if_a.mem_req !== 1'b1) begin n_err++; $display("FAIL wr_req: got %0h exp 1", if_a.mem_req); end
    n_cmp++; if (if_a.mem_we !== 1'b1) begin n_err++; $display("FAIL wr_we: got %0h exp 1", if_a.mem_we); end
    n_cmp++; if (if_a.mem_addr !== 64'h10) begin n_err++; $display("FAIL wr_addr: got %0h exp 10", if_a.mem_addr); end
    n_cmp++; if (if_a.mem_wdata !== 64'hDEAD) begin n_err++; $display("FAIL wr_wdata: got %0h exp dead", if_a.mem_wdata); end
    n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL wr_done_early: got %0h exp 0", done_a); end
    tick();
    n_cmp++; if (done_a !== 1'b1) begin n_err++; $display("FAIL wr_done: got %0h exp 1", done_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_err++; $display("FAIL wr_err: got %0h exp 0", err_a); end
    n_cmp++; if (if_a.mem_req !== 1'b0) begin n_err++; $display("FAIL wr_req_drop: got %0h exp 0", if_a.mem_req); end
    if_a.mem_ready = 1'b0;
    tick();
    n_cmp++; if ({done_a, in_ready_a} !== 2'b01) begin n_err++; $display("FAIL wr_after: got %0h exp 1", {done_a, in_ready_a}); end
    n_cmp++; if (hs_a - hs0 !== 1) begin n_err++; $display("FAIL wr_hs_count: got %0d exp 1", hs_a - hs0); end
  endtask

  task automatic test_mrmovq();
    icode = 4'h5; valE = 64'h20; valA = 64'h77; valP = 64'h0;
    in_valid_a = 1'b1;
    tick(); in_valid_a = 1'b0;
    n_cmp++; if ({stall_a, if_a.mem_req, if_a.mem_we} !== 3'b110) begin n_err++; $display("FAIL rd_req: got %0h exp 6", {stall_a, if_a.mem_req, if_a.mem_we}); end
    n_cmp++; if (if_a.mem_addr !== 64'h20) begin n_err++; $display("FAIL rd_addr: got %0h exp 20", if_a.mem_addr); end
    tick();
    n_cmp++; if ({stall_a, if_a.mem_req} !== 2'b11) begin n_err++; $display("FAIL rd_req_hold: got %0h exp 3", {stall_a, if_a.mem_req}); end
    tick();
    if_a.mem_ready = 1'b1;
    tick(); if_a.mem_ready = 1'b0;
    n_cmp++; if ({stall_a, if_a.mem_req, done_a} !== 3'b100) begin n_err++; $display("FAIL rd_wait: got %0h exp 4", {stall_a, if_a.mem_req, done_a}); end
    tick();
    if_a.mem_rvalid = 1'b1; if_a.mem_rdata = 64'hCAFE;
    tick(); if_a.mem_rvalid = 1'b0;
    n_cmp++; if ({stall_a, done_a, err_a} !== 3'b110) begin n_err++; $display("FAIL rd_done: got %0h exp 6", {stall_a, done_a, err_a}); end
    n_cmp++; if (valM_a !== 64'hCAFE) begin n_err++; $display("FAIL rd_valM: got %0h exp cafe", valM_a); end
    tick();
    n_cmp++; if ({done_a, in_ready_a} !== 2'b01) begin n_err++; $display("FAIL rd_after: got %0h exp 1", {done_a, in_ready_a}); end
    n_cmp++; if (valM_a !== 64'hCAFE) begin n_err++; $display("FAIL rd_valM_hold: got %0h exp cafe", valM_a); end
  endtask

  task automatic test_oob_and_limit();
    int rq0;
    rq0 = req_cyc_a;
    icode = 4'hA; valE = 64'd8192; valA = 64'h5;
    if_a.mem_ready = 1'b1; in_valid_a = 1'b1;
    tick(); in_valid_a = 1'b0;
    n_cmp++; if ({done_a, err_a, if_a.mem_req} !== 3'b110) begin n_err++; $display("FAIL oob_done_err: got %0h exp 6", {done_a, err_a, if_a.mem_req}); end
    n_cmp++; if (valM_a !== 64'h0) begin n_err++; $display("FAIL oob_valM: got %0h exp 0", valM_a); end
    tick();
    n_cmp++; if (req_cyc_a - rq0 !== 0) begin n_err++; $display("FAIL oob_no_req: got %0d exp 0", req_cyc_a - rq0); end
    // last legal word address goes through
    icode = 4'hA; valE = 64'd8191; valA = 64'h42;
    in_valid_a = 1'b1;
    tick(); in_valid_a = 1'b0;
    n_cmp++; if ({if_a.mem_req, if_a.mem_we} !== 2'b11) begin n_err++; $display("FAIL lim_req: got %0h exp 3", {if_a.mem_req, if_a.mem_we}); end
    n_cmp++; if (if_a.mem_addr !== 64'd8191) begin n_err++; $display("FAIL lim_addr: got %0h exp 1fff", if_a.mem_addr); end
    tick();
    n_cmp++; if ({done_a, err_a} !== 2'b10) begin n_err++; $display("FAIL lim_done: got %0h exp 2", {done_a, err_a}); end
    if_a.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_call();
    icode = 4'h8; valE = 64'h40; valA = 64'h2222; valP = 64'h1111;
    if_a.mem_ready = 1'b1; in_valid_a = 1'b1;
    tick(); in_valid_a = 1'b0;
    n_cmp++; if (if_a.mem_wdata !== 64'h1111) begin n_err++; $display("FAIL call_wdata: got %0h exp 1111", if_a.mem_wdata); end
    n_cmp++; if (if_a.mem_addr !== 64'h40) begin n_err++; $display("FAIL call_addr: got %0h exp 40", if_a.mem_addr); end
    tick();
    n_cmp++; if ({done_a, err_a} !== 2'b10) begin n_err++; $display("FAIL call_done: got %0h exp 2", {done_a, err_a}); end
    if_a.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_popq_timeout();
    icode = 4'hB; valA = 64'h8; valE = 64'h999;
    in_valid_b = 1'b1;
    tick(); in_valid_b = 1'b0;
    n_cmp++; if ({if_b.mem_req, if_b.mem_we} !== 2'b10) begin n_err++; $display("FAIL to_req: got %0h exp 2", {if_b.mem_req, if_b.mem_we}); end
    n_cmp++; if (if_b.mem_addr !== 64'h8) begin n_err++; $display("FAIL to_addr: got %0h exp 8", if_b.mem_addr); end
    repeat (3) tick();
    n_cmp++; if ({done_b, if_b.mem_req} !== 2'b01) begin n_err++; $display("FAIL to_before: got %0h exp 1", {done_b, if_b.mem_req}); end
    tick();
    n_cmp++; if ({done_b, err_b, if_b.mem_req} !== 3'b110) begin n_err++; $display("FAIL to_done: got %0h exp 6", {done_b, err_b, if_b.mem_req}); end
    n_cmp++; if (valM_b !== 64'h0) begin n_err++; $display("FAIL to_valM: got %0h exp 0", valM_b); end
    tick();
    n_cmp++; if ({done_b, in_ready_b, stall_b} !== 3'b010) begin n_err++; $display("FAIL to_after: got %0h exp 2", {done_b, in_ready_b, stall_b}); end
  endtask

  task automatic test_timeout_race();
    icode = 4'h5; valE = 64'h18; valA = 64'h0;
    in_valid_b = 1'b1;
    tick(); in_valid_b = 1'b0;
    if_b.mem_ready = 1'b1;
    tick(); if_b.mem_ready = 1'b0;
    tick();
    tick();
    n_cmp++; if ({done_b, stall_b} !== 2'b01) begin n_err++; $display("FAIL race_wait: got %0h exp 1", {done_b, stall_b}); end
    if_b.mem_rvalid = 1'b1; if_b.mem_rdata = 64'h55AA;
    tick(); if_b.mem_rvalid = 1'b0;
    n_cmp++; if ({done_b, err_b} !== 2'b10) begin n_err++; $display("FAIL race_done: got %0h exp 2", {done_b, err_b}); end
    n_cmp++; if (valM_b !== 64'h55AA) begin n_err++; $display("FAIL race_valM: got %0h exp 55aa", valM_b); end
    tick();
  endtask

  task automatic test_reset_mid();
    int rq0;
    icode = 4'h5; valE = 64'h50; valA = 64'h0;
    in_valid_a = 1'b1;
    tick(); in_valid_a = 1'b0;
    if_a.mem_ready = 1'b1;
    tick(); if_a.mem_ready = 1'b0;
    tick();
    n_cmp++; if ({stall_a, if_a.mem_addr} !== {1'b1, 64'h50}) begin n_err++; $display("FAIL mid_wait: got %0h exp 10000000000000050", {stall_a, if_a.mem_addr}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready_a, stall_a, if_a.mem_req, done_a} !== 4'b1000) begin n_err++; $display("FAIL mid_rst: got %0h exp 8", {in_ready_a, stall_a, if_a.mem_req, done_a}); end
    n_cmp++; if (if_a.mem_addr !== 64'h0) begin n_err++; $display("FAIL mid_rst_addr: got %0h exp 0", if_a.mem_addr); end
    tick();
    rst_n = 1'b1;
    tick();
    rq0 = req_cyc_a;
    icode = 4'h1; valE = 64'h60; valA = 64'h60;
    in_valid_a = 1'b1;
    tick(); in_valid_a = 1'b0;
    n_cmp++; if ({done_a, err_a, if_a.mem_req} !== 3'b100) begin n_err++; $display("FAIL nop_done: got %0h exp 4", {done_a, err_a, if_a.mem_req}); end
    n_cmp++; if (valM_a !== 64'h0) begin n_err++; $display("FAIL nop_valM: got %0h exp 0", valM_a); end
    tick();
    n_cmp++; if (req_cyc_a - rq0 !== 0) begin n_err++; $display("FAIL nop_no_req: got %0d exp 0", req_cyc_a - rq0); end
  endtask

  task automatic test_ret();
    icode = 4'h9; valA = 64'h30; valE = 64'h7777;
    in_valid_a = 1'b1;
    tick(); in_valid_a = 1'b0;
    n_cmp++; if (if_a.mem_addr !== 64'h30) begin n_err++; $display("FAIL ret_addr: got %0h exp 30", if_a.mem_addr); end
    if_a.mem_rvalid = 1'b1; if_a.mem_rdata = 64'hBAD;
    tick(); if_a.mem_rvalid = 1'b0;
    n_cmp++; if ({if_a.mem_req, done_a} !== 2'b10) begin n_err++; $display("FAIL ret_ignore: got %0h exp 2", {if_a.mem_req, done_a}); end
    if_a.mem_ready = 1'b1;
    tick(); if_a.mem_ready = 1'b0;
    n_cmp++; if ({if_a.mem_req, done_a, stall_a} !== 3'b001) begin n_err++; $display("FAIL ret_wait: got %0h exp 1", {if_a.mem_req, done_a, stall_a}); end
    if_a.mem_rvalid = 1'b1; if_a.mem_rdata = 64'h1234;
    tick(); if_a.mem_rvalid = 1'b0;
    n_cmp++; if ({done_a, err_a} !== 2'b10) begin n_err++; $display("FAIL ret_done: got %0h exp 2", {done_a, err_a}); end
    n_cmp++; if (valM_a !== 64'h1234) begin n_err++; $display("FAIL ret_valM: got %0h exp 1234", valM_a); end
    tick();
  endtask

  task automatic test_back_to_back();
    icode = 4'h1; in_valid_a = 1'b1;
    tick();
    n_cmp++; if ({done_a, in_ready_a} !== 2'b10) begin n_err++; $display("FAIL b2b_first: got %0h exp 2", {done_a, in_ready_a}); end
    tick();
    n_cmp++; if ({done_a, in_ready_a} !== 2'b01) begin n_err++; $display("FAIL b2b_gap: got %0h exp 1", {done_a, in_ready_a}); end
    tick(); in_valid_a = 1'b0;
    n_cmp++; if ({done_a, in_ready_a} !== 2'b10) begin n_err++; $display("FAIL b2b_second: got %0h exp 2", {done_a, in_ready_a}); end
    tick();
  endtask

  initial begin
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    icode = 4'h0; valA = 64'h0; valE = 64'h0; valP = 64'h0;
    if_a.mem_ready = 1'b0; if_a.mem_rvalid = 1'b0; if_a.mem_rdata = 64'h0;
    if_b.mem_ready = 1'b0; if_b.mem_rvalid = 1'b0; if_b.mem_rdata = 64'h0;
    test_reset();
    test_rmmovq();
    test_mrmovq();
    test_oob_and_limit();
    test_call();
    test_popq_timeout();
    test_timeout_race();
    test_reset_mid();
    test_ret();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
